multi_cycle_cu: RTL and testbench

- Parametrised multi-cycle control unit for the RV32I-subset datapath.
- Owns its own state register, so no external state counter is needed.
- Decodes the opcode, handshakes with a shared instruction/data memory port, and drives the datapath write enables and mux selects.
- Adds load/store, branch, JAL, a memory-stall timeout, an illegal-opcode trap and a retired-instruction counter.

---
 rtl/multi_cycle_cu_pkg.sv | 40 ++++
 rtl/multi_cycle_cu_if.sv | 10 +
 rtl/multi_cycle_cu_out_decode.sv | 73 +++++++
 rtl/multi_cycle_cu.sv | 115 +++++++++++
 tb/tb_multi_cycle_cu.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    IF       = 4'd1,
    ID       = 4'd2,
    EX_R     = 4'd3,
    EX_I     = 4'd4,
    WB_ALU   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BR       = 4'd10,
    JAL      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JAL   = 2'b10;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_wait(input state_t s);
    return s inside {IF, MEM_RD, MEM_WR};
  endfunction

endpackage

// File: rtl/multi_cycle_cu_if.sv
// Shared instruction/data memory request port.
interface multi_cycle_cu_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_s;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_s, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_s, output mem_ready);
endinterface

// File: rtl/multi_cycle_cu_out_decode.sv
// Control-output decode: Moore on state, with IF gated by mem_ready and BR by br_taken.
module cu_out_decode
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_s,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       rs2_imm_s,
  output logic [1:0] w_data_s,
  output logic [1:0] pc_src
);

  // Everything defaults to 0; each state raises only what it needs.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr_s = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    rs2_imm_s  = 1'b0;
    w_data_s   = WD_ALU;
    pc_src     = PC_PLUS4;
    case (state)
      IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      EX_I:     rs2_imm_s = 1'b1;
      WB_ALU: begin
        reg_write = 1'b1;
        w_data_s  = WD_ALU;
      end
      MEM_ADDR: rs2_imm_s = 1'b1;
      MEM_RD: begin
        mem_req    = 1'b1;
        mem_addr_s = 1'b1;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        w_data_s  = WD_MEM;
      end
      MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr_s = 1'b1;
      end
      BR: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_src   = PC_BR;
        end
      end
      JAL: begin
        reg_write = 1'b1;
        w_data_s  = WD_PC;
        pc_write  = 1'b1;
        pc_src    = PC_JAL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle RV32I-subset control unit: state register, memory timeout, retire counter.
module multi_cycle_cu
  import cu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               br_taken,
  multi_cycle_cu_if.master   mem,
  output logic               PC_Write,
  output logic               IR_Write,
  output logic               Reg_Write,
  output logic               rs2_imm_s,
  output logic [1:0]         w_data_s,
  output logic [1:0]         pc_src,
  output logic               trap,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] st
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state, state_nx;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            retire;

  // Last permitted wait cycle with no completion; mem_ready in that cycle still wins.
  assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1)) && !mem.mem_ready;

  // Next-state and retire decision.
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      IDLE:     if (run) state_nx = IF;
      IF: begin
        if (mem.mem_ready) state_nx = ID;
        else if (to_hit)   state_nx = TRAP;
      end
      ID: begin
        case (opcode)
          OP_R:              state_nx = EX_R;
          OP_I:              state_nx = EX_I;
          OP_LOAD, OP_STORE: state_nx = MEM_ADDR;
          OP_BRANCH:         state_nx = BR;
          OP_JAL:            state_nx = JAL;
          default:           state_nx = TRAP;
        endcase
      end
      EX_R, EX_I: state_nx = WB_ALU;
      MEM_ADDR:   state_nx = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem.mem_ready) state_nx = WB_MEM;
        else if (to_hit)   state_nx = TRAP;
      end
      MEM_WR: begin
        if (mem.mem_ready) retire   = 1'b1;
        else if (to_hit)   state_nx = TRAP;
      end
      WB_ALU, WB_MEM, BR, JAL: retire = 1'b1;
      TRAP:       state_nx = TRAP;
      default:    state_nx = TRAP;
    endcase
    if (retire) state_nx = run ? IF : IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Wait-cycle counter: restarts on any state change, advances only while a request is open.
  always_ff @(posedge clk) begin
    if (!rst_n)                 to_cnt <= '0;
    else if (state_nx != state) to_cnt <= '0;
    else if (is_mem_wait(state)) to_cnt <= to_cnt + TO_W'(1);
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Sticky trap flag; TRAP is only left through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) trap <= 1'b0;
    else        trap <= trap | (state_nx == TRAP);
  end

  assign st = STATE_W'(state);

  cu_out_decode u_dec (
    .state      (state),
    .mem_ready  (mem.mem_ready),
    .br_taken   (br_taken),
    .mem_req    (mem.mem_req),
    .mem_we     (mem.mem_we),
    .mem_addr_s (mem.mem_addr_s),
    .pc_write   (PC_Write),
    .ir_write   (IR_Write),
    .reg_write  (Reg_Write),
    .rs2_imm_s  (rs2_imm_s),
    .w_data_s   (w_data_s),
    .pc_src     (pc_src)
  );

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Self-checking bench for multi_cycle_cu: per-instruction expected traces vs. the DUT.
module tb_multi_cycle_cu;
  import cu_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 4;

  logic             clk = 1'b0;
  logic             rst_n, run, br_taken;
  logic [6:0]       opcode;
  logic             PC_Write, IR_Write, Reg_Write, rs2_imm_s, trap;
  logic [1:0]       w_data_s, pc_src;
  logic [CNT_W-1:0] retired;
  logic [3:0]       st;
  logic [10:0]      ctrl_vec;

  multi_cycle_cu_if mif ();

  multi_cycle_cu #(.TIMEOUT(TMO), .CNT_W(CNT_W), .STATE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .mem       (mif.master),
    .PC_Write  (PC_Write),
    .IR_Write  (IR_Write),
    .Reg_Write (Reg_Write),
    .rs2_imm_s (rs2_imm_s),
    .w_data_s  (w_data_s),
    .pc_src    (pc_src),
    .trap      (trap),
    .retired   (retired),
    .st        (st)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {mif.mem_req, mif.mem_we, mif.mem_addr_s, PC_Write, IR_Write,
                     Reg_Write, rs2_imm_s, w_data_s, pc_src};

  // One expected cycle: the state the DUT should be in, the inputs driven then,
  // and whether this cycle completes an instruction.
  typedef struct {
    state_t st;
    bit     rdy;
    bit     br;
    bit     rn;
    bit     ret;
  } step_t;

  step_t       q[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned model_ret = 0;
  bit          at_idle = 1'b1;
  logic [6:0]  ops [6];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit rb();
    return $urandom_range(1, 0) != 0;
  endfunction

  // Control outputs each state must present, straight from the state table.
  function automatic logic [10:0] exp_ctrl(input state_t s, input bit rdy, input bit br);
    logic req, we, as, pcw, irw, rw, imm;
    logic [1:0] wd, ps;
    req = 0; we = 0; as = 0; pcw = 0; irw = 0; rw = 0; imm = 0; wd = 2'b00; ps = 2'b00;
    case (s)
      IF:       begin req = 1; if (rdy) begin pcw = 1; irw = 1; end end
      EX_I:     imm = 1;
      WB_ALU:   rw = 1;
      MEM_ADDR: imm = 1;
      MEM_RD:   begin req = 1; as = 1; end
      WB_MEM:   begin rw = 1; wd = 2'b01; end
      MEM_WR:   begin req = 1; we = 1; as = 1; end
      BR:       if (br) begin pcw = 1; ps = 2'b01; end
      JAL:      begin rw = 1; wd = 2'b10; pcw = 1; ps = 2'b10; end
      default:  ;
    endcase
    return {req, we, as, pcw, irw, rw, imm, wd, ps};
  endfunction

  task automatic push(input state_t s, input bit rdy, input bit br, input bit rn, input bit ret);
    step_t e;
    e.st = s; e.rdy = rdy; e.br = br; e.rn = rn; e.ret = ret;
    q.push_back(e);
  endtask

  // Drive each expected step, check at the falling edge, advance one clock.
  task automatic play(input int unsigned limit);
    step_t e;
    for (int unsigned i = 0; i < limit && q.size() > 0; i++) begin
      e = q.pop_front();
      run = e.rn; mif.mem_ready = e.rdy; br_taken = e.br;
      @(negedge clk);
      check("st", 32'(st), 32'(e.st));
      check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(e.st, e.rdy, e.br)));
      check("trap", 32'(trap), 32'(e.st == TRAP));
      check("retired", 32'(retired), model_ret);
      if (e.ret) model_ret = (model_ret + 1) % (1 << CNT_W);
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic start_from_idle();
    if (at_idle) begin
      push(IDLE, rb(), rb(), 1'b0, 1'b0);
      push(IDLE, rb(), rb(), 1'b1, 1'b0);
      at_idle = 1'b0;
    end
  endtask

  // Expected trace of one instruction from fetch to retire (or to trap).
  task automatic instr(input logic [6:0] op, input int unsigned if_st, input int unsigned mem_st,
                       input bit br, input bit run_after, input int unsigned limit = 1000);
    opcode = op;
    start_from_idle();
    for (int unsigned i = 0; i < if_st; i++) push(IF, 1'b0, rb(), rb(), 1'b0);
    push(IF, 1'b1, rb(), rb(), 1'b0);
    push(ID, rb(), rb(), rb(), 1'b0);
    case (op)
      OP_R: begin
        push(EX_R, rb(), rb(), rb(), 1'b0);
        push(WB_ALU, rb(), rb(), run_after, 1'b1);
      end
      OP_I: begin
        push(EX_I, rb(), rb(), rb(), 1'b0);
        push(WB_ALU, rb(), rb(), run_after, 1'b1);
      end
      OP_LOAD: begin
        push(MEM_ADDR, rb(), rb(), rb(), 1'b0);
        for (int unsigned i = 0; i < mem_st; i++) push(MEM_RD, 1'b0, rb(), rb(), 1'b0);
        push(MEM_RD, 1'b1, rb(), rb(), 1'b0);
        push(WB_MEM, rb(), rb(), run_after, 1'b1);
      end
      OP_STORE: begin
        push(MEM_ADDR, rb(), rb(), rb(), 1'b0);
        for (int unsigned i = 0; i < mem_st; i++) push(MEM_WR, 1'b0, rb(), rb(), 1'b0);
        push(MEM_WR, 1'b1, rb(), run_after, 1'b1);
      end
      OP_BRANCH: push(BR, rb(), br, run_after, 1'b1);
      OP_JAL:    push(JAL, rb(), rb(), run_after, 1'b1);
      default:   for (int unsigned i = 0; i < 20; i++) push(TRAP, rb(), rb(), rb(), 1'b0);
    endcase
    at_idle = !run_after;
    play(limit);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b1; mif.mem_ready = 1'b1; br_taken = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    model_ret = 0; at_idle = 1'b1;
    @(negedge clk);
    check("rst_st", 32'(st), 32'(IDLE));
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_ctrl", 32'(ctrl_vec), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD;
    ops[3] = OP_STORE; ops[4] = OP_BRANCH; ops[5] = OP_JAL;
    rst_n = 1'b0; run = 1'b0; br_taken = 1'b0; opcode = '0; mif.mem_ready = 1'b0;
    do_reset();

    instr(OP_R, 0, 0, 1'b0, 1'b1);
    instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
    instr(OP_BRANCH, 1, 0, 1'b1, 1'b1);
    instr(OP_BRANCH, 0, 0, 1'b0, 1'b1);
    instr(OP_JAL, 0, 0, 1'b0, 1'b0);
    instr(OP_STORE, 2, 2, 1'b0, 1'b1);
    instr(OP_I, 0, 0, 1'b0, 1'b1);
    instr(OP_R, TMO - 1, 0, 1'b0, 1'b1);
    instr(OP_STORE, 0, TMO - 1, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++)
      instr(ops[$urandom_range(5, 0)], $urandom_range(TMO - 1, 0), $urandom_range(TMO - 1, 0),
            rb(), $urandom_range(4, 0) != 0);

    instr(7'b1111111, 0, 0, 1'b0, 1'b1);
    do_reset();

    // Fetch that never completes: TRAP after exactly TMO request cycles.
    opcode = OP_R;
    start_from_idle();
    for (int unsigned i = 0; i < TMO; i++) push(IF, 1'b0, rb(), rb(), 1'b0);
    for (int unsigned i = 0; i < 20; i++) push(TRAP, rb(), rb(), rb(), 1'b0);
    play(1000);
    do_reset();

    // Abort a load while it waits in MEM_RD.
    instr(OP_JAL, 0, 0, 1'b0, 1'b1);
    instr(OP_LOAD, 0, 2, 1'b0, 1'b1, 4);
    do_reset();
    instr(OP_R, 0, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
